// File: rtl/decade7_check.sv
// decade7_check: receive-side checker for a 2-of-5 decade ring counter.
//
// Watches the ring value {a,b,c,d,e} and the set0/set9/advance strobes that drive
// the ring. It decodes the ring to BCD and flags any code that does not have
// exactly two bits set. It also checks that every ring change is the one the
// strobes asked for.
//
// It raises a one-cycle carry on the 9->0 advance and keeps sticky error flags.
//
// Ports:
//   i_clk, i_reset     clock and synchronous active-high reset
//   i_ring[4:0]        ring value {a,b,c,d,e}
//   i_set0/i_set9/i_advance  level strobes shared with the counter (edge-detected here)
//   i_clear_err        clears sticky flags and the error counter
//   o_bcd[3:0]         registered decode, 4'hF when illegal
//   o_code_ok          registered ring is a legal 2-of-5 code
//   o_carry            one-cycle pulse on a checked 9->0 advance
//   o_code_err         sticky illegal-code flag
//   o_seq_err          sticky wrong-step flag
//   o_primed           sequence checking active (armed by a set0/set9)
//   o_err_count        error-cycle count, only built with DECADE7_CHECK_ERRCNT_EN
//
// Optional feature macro: DECADE7_CHECK_ERRCNT_EN (saturating error counter).
module decade7_check #(
  parameter bit          CHECK_SPURIOUS = 1'b1,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [4:0]           i_ring,
  input  logic                 i_set0,
  input  logic                 i_set9,
  input  logic                 i_advance,
  input  logic                 i_clear_err,
  output logic [3:0]           o_bcd,
  output logic                 o_code_ok,
  output logic                 o_carry,
  output logic                 o_code_err,
  output logic                 o_seq_err,
  output logic                 o_primed,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  typedef enum logic [1:0] {KindSet0, KindSet9, KindAdv} kind_e;

  localparam logic [4:0] Code0 = 5'b00011;
  localparam logic [4:0] Code9 = 5'b00101;

  function automatic logic [3:0] decode(input logic [4:0] r);
    logic [3:0] d;
    case (r)
      5'b00011: d = 4'd0;
      5'b10010: d = 4'd1;
      5'b10001: d = 4'd2;
      5'b01001: d = 4'd3;
      5'b11000: d = 4'd4;
      5'b10100: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b01010: d = 4'd7;
      5'b00110: d = 4'd8;
      5'b00101: d = 4'd9;
      default:  d = 4'hF;
    endcase
    return d;
  endfunction

  function automatic logic [4:0] encode(input logic [3:0] d);
    logic [4:0] r;
    case (d)
      4'd1:    r = 5'b10010;
      4'd2:    r = 5'b10001;
      4'd3:    r = 5'b01001;
      4'd4:    r = 5'b11000;
      4'd5:    r = 5'b10100;
      4'd6:    r = 5'b01100;
      4'd7:    r = 5'b01010;
      4'd8:    r = 5'b00110;
      4'd9:    r = 5'b00101;
      default: r = 5'b00011;
    endcase
    return r;
  endfunction

  logic       last_set0, last_set9, last_advance;
  logic       pending;
  logic [4:0] r_ring;
  logic [4:0] r_expect;
  logic       r_expect_ok;
  kind_e      r_kind;

  logic       ev_set0, ev_set9, ev_adv, event_any;
  logic [3:0] in_bcd, succ_digit;
  logic       in_legal;
  logic [4:0] new_expect;
  logic       new_expect_ok;
  kind_e      new_kind;
  logic       code_err_det, seq_err_det, carry_det, prime_det;

  assign ev_set9   = i_set9 & ~last_set9;
  assign ev_set0   = i_set0 & ~last_set0;
  assign ev_adv    = i_advance & ~last_advance;
  assign event_any = ev_set9 | ev_set0 | ev_adv;

  assign in_bcd     = decode(i_ring);
  assign in_legal   = (in_bcd != 4'hF);
  assign succ_digit = (in_bcd == 4'd9) ? 4'd0 : in_bcd + 4'd1;

  // Priority set9 > set0 > advance, matching the counter.
  always_comb begin
    new_expect    = Code0;
    new_expect_ok = 1'b1;
    new_kind      = KindSet0;
    if (ev_set9) begin
      new_expect = Code9;
      new_kind   = KindSet9;
    end else if (ev_set0) begin
      new_expect = Code0;
      new_kind   = KindSet0;
    end else if (ev_adv) begin
      new_expect    = encode(succ_digit);
      new_expect_ok = in_legal;  // advancing from an illegal code has no valid successor
      new_kind      = KindAdv;
    end
  end

  always_comb begin
    code_err_det = ~in_legal;
    seq_err_det  = 1'b0;
    carry_det    = 1'b0;
    prime_det    = 1'b0;
    if (pending) begin
      seq_err_det = o_primed & (~r_expect_ok | (i_ring != r_expect));
      carry_det   = r_expect_ok & (r_kind == KindAdv) & (r_expect == Code0) & (i_ring == Code0);
      prime_det   = (r_kind != KindAdv);
    end else begin
      // Ring moved with nothing asking it to.
      seq_err_det = CHECK_SPURIOUS & o_primed & (i_ring != r_ring);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_set0    <= 1'b0;
      last_set9    <= 1'b0;
      last_advance <= 1'b0;
      pending      <= 1'b0;
      r_ring       <= 5'b00000;
      r_expect     <= 5'b00000;
      r_expect_ok  <= 1'b0;
      r_kind       <= KindSet0;
      o_bcd        <= 4'hF;
      o_code_ok    <= 1'b0;
      o_carry      <= 1'b0;
      o_code_err   <= 1'b0;
      o_seq_err    <= 1'b0;
      o_primed     <= 1'b0;
    end else begin
      last_set0    <= i_set0;
      last_set9    <= i_set9;
      last_advance <= i_advance;
      r_ring       <= i_ring;
      o_bcd        <= in_bcd;
      o_code_ok    <= in_legal;
      o_carry      <= carry_det;
      // A completing event and a new event on the same edge pipeline cleanly.
      pending      <= event_any;
      if (event_any) begin
        r_expect    <= new_expect;
        r_expect_ok <= new_expect_ok;
        r_kind      <= new_kind;
      end
      // A freshly detected error beats a simultaneous clear.
      if (code_err_det)     o_code_err <= 1'b1;
      else if (i_clear_err) o_code_err <= 1'b0;
      if (seq_err_det)      o_seq_err  <= 1'b1;
      else if (i_clear_err) o_seq_err  <= 1'b0;
      if (code_err_det)     o_primed   <= 1'b0;
      else if (prime_det)   o_primed   <= 1'b1;
    end
  end

`ifdef DECADE7_CHECK_ERRCNT_EN
  logic                 err_det;
  logic [ERR_CNT_W-1:0] err_count;

  assign err_det = code_err_det | seq_err_det;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_count <= '0;
    end else if (i_clear_err) begin
      err_count <= err_det ? ERR_CNT_W'(1) : '0;
    end else if (err_det && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign o_err_count = err_count;
`else
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_decade7_check.sv
// Randomized + directed bench for decade7_check against a digit-level reference model.
module tb_decade7_check;

  localparam bit          ChkSp = 1'b1;
  localparam int unsigned ErrW  = 8;
  localparam int          CntMax = (1 << ErrW) - 1;

  logic            i_clk = 1'b0;
  logic            i_reset, i_set0, i_set9, i_advance, i_clear_err;
  logic [4:0]      i_ring;
  logic [3:0]      o_bcd;
  logic            o_code_ok, o_carry, o_code_err, o_seq_err, o_primed;
  logic [ErrW-1:0] o_err_count;

  decade7_check #(
    .CHECK_SPURIOUS(ChkSp),
    .ERR_CNT_W     (ErrW)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ring     (i_ring),
    .i_set0     (i_set0),
    .i_set9     (i_set9),
    .i_advance  (i_advance),
    .i_clear_err(i_clear_err),
    .o_bcd      (o_bcd),
    .o_code_ok  (o_code_ok),
    .o_carry    (o_carry),
    .o_code_err (o_code_err),
    .o_seq_err  (o_seq_err),
    .o_primed   (o_primed),
    .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  // Digit -> ring code.
  logic [4:0] code_tab [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                                5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in digits (-1 = illegal).
  bit m_l0, m_l9, m_la, m_pending, m_primed, m_carry, m_ok, m_code_err, m_seq_err;
  int m_exp, m_kind, m_bcd, m_cnt;  // kind: 0 set0, 1 set9, 2 advance
  logic [4:0] m_prev;

  logic [4:0] ring_cur;

  function automatic int digit_of(input logic [4:0] r);
    for (int i = 0; i < 10; i++) if (code_tab[i] == r) return i;
    return -1;
  endfunction

  function automatic logic [4:0] next_ring(input logic [4:0] r);
    int d;
    d = digit_of(r);
    if (d < 0) return r;
    return code_tab[(d + 1) % 10];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_l0 = 0; m_l9 = 0; m_la = 0; m_pending = 0; m_primed = 0; m_carry = 0; m_ok = 0;
    m_code_err = 0; m_seq_err = 0; m_exp = 0; m_kind = 0; m_bcd = 15; m_cnt = 0;
    m_prev = 5'b00000;
  endtask

  task automatic model_step();
    int d;
    bit code_bad, seq_bad, carry, prime, r0, r9, ra;
    if (i_reset) begin
      model_reset();
      return;
    end
    d = digit_of(i_ring);
    code_bad = (d < 0);
    seq_bad = 0; carry = 0; prime = 0;
    if (m_pending) begin
      if (m_primed && (m_exp < 0 || d != m_exp)) seq_bad = 1;
      if (m_kind == 2 && m_exp == 0 && d == 0) carry = 1;
      if (m_kind != 2) prime = 1;
    end else if (ChkSp && m_primed && i_ring != m_prev) begin
      seq_bad = 1;
    end
    r9 = i_set9 && !m_l9;
    r0 = i_set0 && !m_l0;
    ra = i_advance && !m_la;
    if (r9) begin m_exp = 9; m_kind = 1; end
    else if (r0) begin m_exp = 0; m_kind = 0; end
    else if (ra) begin m_exp = (d < 0) ? -1 : (d + 1) % 10; m_kind = 2; end
    m_pending = r9 || r0 || ra;
    if (code_bad) m_primed = 0;
    else if (prime) m_primed = 1;
    m_code_err = code_bad ? 1'b1 : (i_clear_err ? 1'b0 : m_code_err);
    m_seq_err  = seq_bad  ? 1'b1 : (i_clear_err ? 1'b0 : m_seq_err);
`ifdef DECADE7_CHECK_ERRCNT_EN
    if (i_clear_err) m_cnt = (code_bad || seq_bad) ? 1 : 0;
    else if ((code_bad || seq_bad) && m_cnt != CntMax) m_cnt++;
`else
    m_cnt = 0;
`endif
    m_bcd = (d < 0) ? 15 : d;
    m_ok = !code_bad;
    m_carry = carry;
    m_prev = i_ring;
    m_l0 = i_set0; m_l9 = i_set9; m_la = i_advance;
  endtask

  task automatic compare_all();
    check_eq("bcd",      32'(o_bcd),       32'(m_bcd));
    check_eq("code_ok",  32'(o_code_ok),   32'(m_ok));
    check_eq("carry",    32'(o_carry),     32'(m_carry));
    check_eq("code_err", 32'(o_code_err),  32'(m_code_err));
    check_eq("seq_err",  32'(o_seq_err),   32'(m_seq_err));
    check_eq("primed",   32'(o_primed),    32'(m_primed));
    check_eq("err_count",32'(o_err_count), 32'(m_cnt));
  endtask

  task automatic cycle(input logic [4:0] ring, input logic s0, input logic s9, input logic adv,
                       input logic clr, input logic rst);
    i_ring = ring; i_set0 = s0; i_set9 = s9; i_advance = adv; i_clear_err = clr; i_reset = rst;
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic adv_pulse();
    cycle(ring_cur, 0, 0, 1, 0, 0);
    ring_cur = next_ring(ring_cur);
    cycle(ring_cur, 0, 0, 0, 0, 0);
  endtask

  task automatic set0_pulse();
    cycle(ring_cur, 1, 0, 0, 0, 0);
    ring_cur = code_tab[0];
    cycle(ring_cur, 0, 0, 0, 0, 0);
  endtask

  int exp_cnt1;
  logic s0, s9, adv, clr, rst, c0, c9, ca;

  initial begin
`ifdef DECADE7_CHECK_ERRCNT_EN
    exp_cnt1 = 1;
`else
    exp_cnt1 = 0;
`endif
    model_reset();
    ring_cur = code_tab[0];
    i_ring = ring_cur; i_set0 = 0; i_set9 = 0; i_advance = 0; i_clear_err = 0; i_reset = 1;
    @(posedge i_clk);
    #1;
    cycle(ring_cur, 0, 0, 0, 0, 1);
    check_eq("rst_bcd",    32'(o_bcd),     32'hF);
    check_eq("rst_primed", 32'(o_primed),  32'd0);
    check_eq("rst_ok",     32'(o_code_ok), 32'd0);

    // Prime with set0 on ring 0.
    set0_pulse();
    check_eq("prime_bcd",    32'(o_bcd),      32'd0);
    check_eq("prime_ok",     32'(o_code_ok),  32'd1);
    check_eq("prime_primed", 32'(o_primed),   32'd1);
    check_eq("prime_err",    32'({o_code_err, o_seq_err}), 32'd0);

    // Ten advances 1..9,0 with carry only on the wrap.
    for (int k = 1; k <= 10; k++) begin
      adv_pulse();
      check_eq("step_bcd",   32'(o_bcd),   32'(k % 10));
      check_eq("step_carry", 32'(o_carry), 32'(k == 10));
    end
    check_eq("steps_seq", 32'(o_seq_err), 32'd0);

    // Stuck ring at 3.
    for (int k = 0; k < 3; k++) adv_pulse();
    cycle(ring_cur, 0, 0, 1, 0, 0);
    cycle(ring_cur, 0, 0, 0, 0, 0);
    check_eq("stuck_seq", 32'(o_seq_err), 32'd1);
    for (int k = 0; k < 3; k++) cycle(ring_cur, 0, 0, 0, 0, 0);
    check_eq("stuck_sticky", 32'(o_seq_err), 32'd1);
    cycle(ring_cur, 0, 0, 0, 1, 0);
    check_eq("stuck_clear", 32'(o_seq_err), 32'd0);

    // Illegal code at 5.
    adv_pulse();
    adv_pulse();
    cycle(5'b00111, 0, 0, 0, 0, 0);
    check_eq("ill_bcd",    32'(o_bcd),       32'hF);
    check_eq("ill_ok",     32'(o_code_ok),   32'd0);
    check_eq("ill_err",    32'(o_code_err),  32'd1);
    check_eq("ill_primed", 32'(o_primed),    32'd0);
    check_eq("ill_cnt",    32'(o_err_count), 32'(exp_cnt1));
    cycle(ring_cur, 0, 0, 0, 0, 0);
    cycle(ring_cur, 0, 0, 0, 1, 0);

    // set9 and advance together at 2.
    set0_pulse();
    adv_pulse();
    adv_pulse();
    cycle(ring_cur, 0, 1, 1, 0, 0);
    ring_cur = code_tab[9];
    cycle(ring_cur, 0, 0, 0, 0, 0);
    check_eq("s9a_bcd",   32'(o_bcd),     32'd9);
    check_eq("s9a_seq",   32'(o_seq_err), 32'd0);
    check_eq("s9a_carry", 32'(o_carry),   32'd0);

    // Spurious change at 7, then clear colliding with a fresh error.
    for (int k = 0; k < 8; k++) adv_pulse();
    cycle(5'b00110, 0, 0, 0, 0, 0);
    check_eq("spur_seq", 32'(o_seq_err), 32'd1);
    cycle(5'b01010, 0, 0, 0, 1, 0);
    check_eq("clr_win_seq", 32'(o_seq_err),   32'd1);
    check_eq("clr_win_cnt", 32'(o_err_count), 32'(exp_cnt1));
    ring_cur = 5'b01010;
    cycle(ring_cur, 0, 0, 0, 1, 0);
    check_eq("clr_done", 32'(o_seq_err), 32'd0);

    // Random phase: emulate the counter with occasional faults, clears and resets.
    c0 = 0; c9 = 0; ca = 0;
    for (int n = 0; n < 3000; n++) begin
      s0  = ($urandom_range(0, 15) == 0);
      s9  = ($urandom_range(0, 19) == 0);
      adv = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) ring_cur = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 59) == 0) ring_cur = code_tab[$urandom_range(0, 9)];
      cycle(ring_cur, s0, s9, adv, clr, rst);
      if (s9 && !c9) ring_cur = code_tab[9];
      else if (s0 && !c0) ring_cur = code_tab[0];
      else if (adv && !ca) ring_cur = next_ring(ring_cur);
      c0 = s0; c9 = s9; ca = adv;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
